// File: rtl/itch_msg_parser.sv
// ITCH 5.0 multi-type message parser: length-prefixed messages in, one
// normalized order event (ADD/DELETE/EXECUTE/CANCEL) out with backpressure.
module itch_msg_parser #(
    parameter int DATA_BYTES  = 8,
    parameter int MAX_MSG_LEN = 48,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*DATA_BYTES-1:0] s_axis_tdata,
    input  logic [DATA_BYTES-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    m_evt_valid,
    input  logic                    m_evt_ready,
    output logic [2:0]              m_evt_type,
    output logic                    m_evt_attrib,
    output logic [15:0]             m_evt_locate,
    output logic [47:0]             m_evt_timestamp,
    output logic [63:0]             m_evt_order_ref,
    output logic                    m_evt_side,
    output logic [31:0]             m_evt_shares,
    output logic [63:0]             m_evt_stock,
    output logic [31:0]             m_evt_price,
    output logic [CNT_W-1:0]        msg_count,
    output logic [CNT_W-1:0]        evt_count,
    output logic [CNT_W-1:0]        err_count
);

    if (DATA_BYTES != 4 && DATA_BYTES != 8 && DATA_BYTES != 16) begin : g_bad_width
        $error("itch_msg_parser: DATA_BYTES must be 4, 8 or 16");
    end

    // Buffer always holds at least the 40 bytes an 'F' message decodes from.
    localparam int BUF_N = (MAX_MSG_LEN > 40) ? MAX_MSG_LEN : 40;
    localparam int IDX_W = $clog2(BUF_N);

    typedef enum logic [1:0] {S_LEN_HI, S_LEN_LO, S_BODY, S_DROP} state_t;

    state_t           r_state, w_state;
    logic [15:0]      r_len, w_len;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic [7:0]       r_buf [BUF_N];
    logic [7:0]       w_buf [BUF_N];
    logic [7:0]       w_lane [DATA_BYTES];

    logic             w_accept;
    logic             w_emit;
    logic [2:0]       w_typ;
    logic [15:0]      w_req;
    logic [CNT_W-1:0] w_msg_inc, w_err_inc;

    logic             w_attrib, w_side;
    logic [15:0]      w_locate;
    logic [47:0]      w_ts;
    logic [63:0]      w_ref, w_stock;
    logic [31:0]      w_shares, w_price;

    logic             r_evt_valid;
    logic [2:0]       r_evt_type;
    logic             r_evt_attrib, r_evt_side;
    logic [15:0]      r_evt_locate;
    logic [47:0]      r_evt_ts;
    logic [63:0]      r_evt_ref, r_evt_stock;
    logic [31:0]      r_evt_shares, r_evt_price;
    logic [CNT_W-1:0] r_msg_count, r_evt_count, r_err_count;

    for (genvar g = 0; g < DATA_BYTES; g++) begin : g_lane
        assign w_lane[g] = s_axis_tdata[8*(DATA_BYTES-1-g) +: 8];
    end

    assign s_axis_tready = !r_evt_valid || m_evt_ready;
    assign w_accept      = s_axis_tvalid && s_axis_tready;

    always_comb begin
        w_state   = r_state;
        w_len     = r_len;
        w_idx     = r_idx;
        w_buf     = r_buf;
        w_msg_inc = '0;
        w_err_inc = '0;
        w_emit    = 1'b0;
        w_typ     = '0;
        w_req     = '0;
        w_attrib  = 1'b0;
        w_side    = 1'b0;
        w_locate  = '0;
        w_ts      = '0;
        w_ref     = '0;
        w_stock   = '0;
        w_shares  = '0;
        w_price   = '0;
        if (w_accept) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (s_axis_tkeep[i]) begin
                    unique case (w_state)
                        S_LEN_HI: begin
                            w_len[15:8] = w_lane[i];
                            w_state     = S_LEN_LO;
                        end
                        S_LEN_LO: begin
                            w_len[7:0] = w_lane[i];
                            if (w_len == 16'd0 || w_len > 16'(MAX_MSG_LEN)) begin
                                w_err_inc = w_err_inc + CNT_W'(1);
                                w_state   = S_DROP;
                            end else begin
                                w_idx   = '0;
                                w_state = S_BODY;
                            end
                        end
                        S_BODY: begin
                            w_buf[w_idx] = w_lane[i];
                            if (16'(w_idx) == w_len - 16'd1) begin
                                w_msg_inc = w_msg_inc + CNT_W'(1);
                                w_state   = S_LEN_HI;
                                case (w_buf[0])
                                    8'h41:   begin w_typ = 3'd1; w_req = 16'd36; end
                                    8'h46:   begin w_typ = 3'd1; w_req = 16'd40; end
                                    8'h44:   begin w_typ = 3'd2; w_req = 16'd19; end
                                    8'h45:   begin w_typ = 3'd3; w_req = 16'd31; end
                                    8'h58:   begin w_typ = 3'd4; w_req = 16'd23; end
                                    default: begin w_typ = 3'd0; w_req = 16'd0;  end
                                endcase
                                if (w_typ != 3'd0 && w_req != w_len) begin
                                    w_err_inc = w_err_inc + CNT_W'(1);
                                end else if (w_typ != 3'd0) begin
                                    // Decode now: later bytes of this beat may reuse the buffer.
                                    w_emit   = 1'b1;
                                    w_attrib = (w_buf[0] == 8'h46);
                                    w_locate = {w_buf[1], w_buf[2]};
                                    w_ts     = {w_buf[5], w_buf[6], w_buf[7],
                                                w_buf[8], w_buf[9], w_buf[10]};
                                    w_ref    = {w_buf[11], w_buf[12], w_buf[13], w_buf[14],
                                                w_buf[15], w_buf[16], w_buf[17], w_buf[18]};
                                    if (w_typ == 3'd1) begin
                                        w_side   = (w_buf[19] == 8'h53);
                                        w_shares = {w_buf[20], w_buf[21], w_buf[22], w_buf[23]};
                                        w_stock  = {w_buf[24], w_buf[25], w_buf[26], w_buf[27],
                                                    w_buf[28], w_buf[29], w_buf[30], w_buf[31]};
                                        w_price  = {w_buf[32], w_buf[33], w_buf[34], w_buf[35]};
                                    end else if (w_typ != 3'd2) begin
                                        w_shares = {w_buf[19], w_buf[20], w_buf[21], w_buf[22]};
                                    end
                                end
                            end else begin
                                w_idx = w_idx + IDX_W'(1);
                            end
                        end
                        S_DROP: begin
                            w_state = S_DROP;
                        end
                    endcase
                end
            end
            if (s_axis_tlast) begin
                if (w_state != S_LEN_HI && w_state != S_DROP) begin
                    w_err_inc = w_err_inc + CNT_W'(1);
                end
                w_state = S_LEN_HI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_LEN_HI;
            r_len        <= '0;
            r_idx        <= '0;
            for (int i = 0; i < BUF_N; i++) begin
                r_buf[i] <= '0;
            end
            r_evt_valid  <= 1'b0;
            r_evt_type   <= '0;
            r_evt_attrib <= 1'b0;
            r_evt_side   <= 1'b0;
            r_evt_locate <= '0;
            r_evt_ts     <= '0;
            r_evt_ref    <= '0;
            r_evt_stock  <= '0;
            r_evt_shares <= '0;
            r_evt_price  <= '0;
            r_msg_count  <= '0;
            r_evt_count  <= '0;
            r_err_count  <= '0;
        end else begin
            r_state     <= w_state;
            r_len       <= w_len;
            r_idx       <= w_idx;
            r_buf       <= w_buf;
            r_msg_count <= r_msg_count + w_msg_inc;
            r_err_count <= r_err_count + w_err_inc;
            if (w_accept && w_emit) begin
                r_evt_valid  <= 1'b1;
                r_evt_type   <= w_typ == 3'd1 ? 3'd1 : w_typ;
                r_evt_attrib <= w_attrib;
                r_evt_side   <= w_side;
                r_evt_locate <= w_locate;
                r_evt_ts     <= w_ts;
                r_evt_ref    <= w_ref;
                r_evt_stock  <= w_stock;
                r_evt_shares <= w_shares;
                r_evt_price  <= w_price;
                r_evt_count  <= r_evt_count + CNT_W'(1);
            end else if (m_evt_ready) begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign m_evt_valid     = r_evt_valid;
    assign m_evt_type      = r_evt_type;
    assign m_evt_attrib    = r_evt_attrib;
    assign m_evt_locate    = r_evt_locate;
    assign m_evt_timestamp = r_evt_ts;
    assign m_evt_order_ref = r_evt_ref;
    assign m_evt_side      = r_evt_side;
    assign m_evt_shares    = r_evt_shares;
    assign m_evt_stock     = r_evt_stock;
    assign m_evt_price     = r_evt_price;
    assign msg_count       = r_msg_count;
    assign evt_count       = r_evt_count;
    assign err_count       = r_err_count;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Bench for itch_msg_parser: directed frames plus random packets checked
// against a message-level model of expected events and counters.
module tb_itch_msg_parser;

    localparam int DB = 8;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [8*DB-1:0] s_axis_tdata;
    logic [DB-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic          m_evt_valid;
    logic          m_evt_ready;
    logic [2:0]    m_evt_type;
    logic          m_evt_attrib;
    logic [15:0]   m_evt_locate;
    logic [47:0]   m_evt_timestamp;
    logic [63:0]   m_evt_order_ref;
    logic          m_evt_side;
    logic [31:0]   m_evt_shares;
    logic [63:0]   m_evt_stock;
    logic [31:0]   m_evt_price;
    logic [CW-1:0] msg_count;
    logic [CW-1:0] evt_count;
    logic [CW-1:0] err_count;

    always #5 clk = ~clk;

    itch_msg_parser #(.DATA_BYTES(DB), .MAX_MSG_LEN(48), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_evt_valid(m_evt_valid), .m_evt_ready(m_evt_ready),
        .m_evt_type(m_evt_type), .m_evt_attrib(m_evt_attrib),
        .m_evt_locate(m_evt_locate), .m_evt_timestamp(m_evt_timestamp),
        .m_evt_order_ref(m_evt_order_ref), .m_evt_side(m_evt_side),
        .m_evt_shares(m_evt_shares), .m_evt_stock(m_evt_stock),
        .m_evt_price(m_evt_price),
        .msg_count(msg_count), .evt_count(evt_count), .err_count(err_count)
    );

    typedef struct packed {
        logic [2:0]  typ;
        logic        attrib;
        logic [15:0] locate;
        logic [47:0] ts;
        logic [63:0] oref;
        logic        side;
        logic [31:0] shares;
        logic [63:0] stock;
        logic [31:0] price;
    } evt_t;

    evt_t       got;
    evt_t       prev;
    evt_t       mon_e;
    evt_t       exp_q[$];
    logic [7:0] pkt[$];
    int         checks = 0;
    int         failures = 0;
    int         msg_exp = 0;
    int         evt_exp = 0;
    int         err_exp = 0;
    int         hold = 0;
    bit         rmode = 1'b0;
    bit         last_tready = 1'b0;
    bit         saw_stall = 1'b0;
    bit         have_prev = 1'b0;

    assign got = {m_evt_type, m_evt_attrib, m_evt_locate, m_evt_timestamp,
                  m_evt_order_ref, m_evt_side, m_evt_shares, m_evt_stock,
                  m_evt_price};

    // Event monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!rst_n || !m_evt_valid) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                checks++;
                assert (got === prev) else begin
                    failures++;
                    $error("FAIL evt_stable got=%h exp=%h", got, prev);
                end
            end
            if (m_evt_ready) begin
                have_prev = 1'b0;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL evt_unexpected got=%h exp=none", got);
                end
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    checks++;
                    assert (got === mon_e) else begin
                        failures++;
                        $error("FAIL evt_fields got=%h exp=%h", got, mon_e);
                    end
                end
            end else begin
                prev      = got;
                have_prev = 1'b1;
            end
        end
    end

    function automatic int req_len(input logic [7:0] tc);
        case (tc)
            "A": return 36;
            "F": return 40;
            "D": return 19;
            "E": return 31;
            "X": return 23;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] g, input logic [63:0] e);
        checks++;
        assert (g === e) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, g, e);
        end
    endtask

    task automatic tick();
        if (hold > 0) begin
            m_evt_ready = 1'b0;
            hold--;
        end else if (rmode) begin
            m_evt_ready = ($urandom_range(0, 3) != 0);
        end else begin
            m_evt_ready = 1'b1;
        end
        @(negedge clk);
        last_tready = s_axis_tready;
        @(posedge clk);
        #1;
    endtask

    // Appends one framed message; keep < len+2 truncates it inside the frame.
    task automatic add_msg(input logic [7:0] tc, input int len, input int keep,
                           input logic [63:0] oref, input logic [31:0] sh,
                           input logic sd, input logic [63:0] stk,
                           input logic [31:0] pr);
        logic [7:0]  body [64];
        logic [15:0] loc;
        logic [47:0] ts;
        logic [15:0] l16;
        int          req;
        evt_t        e;
        loc = 16'($urandom);
        ts  = {16'($urandom), $urandom};
        l16 = 16'(len);
        for (int i = 0; i < 64; i++) body[i] = 8'($urandom);
        body[0] = tc;
        body[1] = loc[15:8];
        body[2] = loc[7:0];
        for (int k = 0; k < 6; k++) body[5+k] = ts[47-8*k -: 8];
        for (int k = 0; k < 8; k++) body[11+k] = oref[63-8*k -: 8];
        if (tc == "A" || tc == "F") begin
            body[19] = sd ? "S" : "B";
            for (int k = 0; k < 4; k++) body[20+k] = sh[31-8*k -: 8];
            for (int k = 0; k < 8; k++) body[24+k] = stk[63-8*k -: 8];
            for (int k = 0; k < 4; k++) body[32+k] = pr[31-8*k -: 8];
        end else if (tc == "E" || tc == "X") begin
            for (int k = 0; k < 4; k++) body[19+k] = sh[31-8*k -: 8];
        end
        pkt.push_back(l16[15:8]);
        if (keep >= 2) pkt.push_back(l16[7:0]);
        for (int i = 0; i < len && i + 2 < keep; i++) pkt.push_back(body[i]);
        if (keep < len + 2) begin
            err_exp++;
            return;
        end
        msg_exp++;
        req = req_len(tc);
        if (req == 0) return;
        if (req != len) begin
            err_exp++;
            return;
        end
        e.typ    = (tc == "A" || tc == "F") ? 3'd1 : (tc == "D") ? 3'd2 :
                   (tc == "E") ? 3'd3 : 3'd4;
        e.attrib = (tc == "F");
        e.locate = loc;
        e.ts     = ts;
        e.oref   = oref;
        e.side   = (e.typ == 3'd1) ? sd : 1'b0;
        e.shares = (e.typ == 3'd2) ? 32'd0 : sh;
        e.stock  = (e.typ == 3'd1) ? stk : 64'd0;
        e.price  = (e.typ == 3'd1) ? pr : 32'd0;
        exp_q.push_back(e);
        evt_exp++;
    endtask

    task automatic add_bad(input logic [15:0] l16, input int junk);
        pkt.push_back(l16[15:8]);
        pkt.push_back(l16[7:0]);
        for (int i = 0; i < junk; i++) pkt.push_back(8'($urandom));
        err_exp++;
    endtask

    task automatic send_pkt(input int max_beats);
        int p;
        int nb;
        int guard;
        p  = 0;
        nb = 0;
        while (p < pkt.size() && nb < max_beats) begin
            s_axis_tdata = '0;
            s_axis_tkeep = '0;
            for (int l = 0; l < DB; l++) begin
                if (p + l < pkt.size()) begin
                    s_axis_tdata[8*(DB-1-l) +: 8] = pkt[p+l];
                    s_axis_tkeep[l] = 1'b1;
                end
            end
            s_axis_tlast  = (p + DB >= pkt.size());
            s_axis_tvalid = 1'b1;
            guard = 0;
            do begin
                tick();
                guard++;
                if (!last_tready) saw_stall = 1'b1;
            end while (!last_tready && guard < 64);
            if (!last_tready) begin
                checks++;
                failures++;
                $error("FAIL tready_timeout got=0 exp=1");
                break;
            end
            p += DB;
            nb++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tkeep  = '0;
        s_axis_tdata  = '0;
        pkt.delete();
    endtask

    task automatic drain();
        int guard;
        rmode = 1'b0;
        guard = 0;
        while ((m_evt_valid || hold > 0) && guard < 200) begin
            tick();
            guard++;
        end
        tick();
        chk("drain_valid", 64'(m_evt_valid), 64'd0);
        chk("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_msg"}, 64'(msg_count), 64'(msg_exp));
        chk({tag, "_err"}, 64'(err_count), 64'(err_exp));
    endtask

    logic [7:0] tcs [7];
    int         nm;
    int         r;
    int         len;
    int         req;
    logic [7:0] tc;

    initial begin
        tcs = '{"A", "F", "D", "E", "X", "S", "Q"};
        rst_n         = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_evt_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(m_evt_valid), 64'd0);
        chk("rst_msg", 64'(msg_count), 64'd0);
        chk("rst_evt", 64'(evt_count), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single Add Order: event registered at the edge accepting beat 5
        add_msg("A", 36, 38, 64'h1122334455667788, 32'd100, 1'b1,
                64'h4141504C20202020, 32'd1500000);
        send_pkt(1000);
        chk("t1_valid", 64'(m_evt_valid), 64'd1);
        chk("t1_type", 64'(m_evt_type), 64'd1);
        chk("t1_side", 64'(m_evt_side), 64'd1);
        chk("t1_shares", 64'(m_evt_shares), 64'd100);
        chk("t1_price", 64'(m_evt_price), 64'd1500000);
        chk("t1_msg", 64'(msg_count), 64'd1);
        chk("t1_evt", 64'(evt_count), 64'd1);
        drain();

        // D/E/X back to back, misaligned
        add_msg("D", 19, 21, 64'd7, 32'd0, 1'b0, 64'd0, 32'd0);
        add_msg("E", 31, 33, 64'd7, 32'd50, 1'b0, 64'd0, 32'd0);
        add_msg("X", 23, 25, 64'd9, 32'd10, 1'b0, 64'd0, 32'd0);
        send_pkt(1000);
        drain();
        chk("t2_err", 64'(err_count), 64'd0);
        chk("t2_evt", 64'(evt_count), 64'd4);
        chk_counts("t2");

        // Oversize length, then a valid delete in the next packet
        add_bad(16'h00FF, 5);
        send_pkt(1000);
        chk("t3_err", 64'(err_count), 64'd1);
        add_msg("D", 19, 21, 64'($urandom), 32'd0, 1'b0, 64'd0, 32'd0);
        send_pkt(1000);
        drain();
        chk_counts("t3");

        // Truncated Add after 20 body bytes
        add_msg("A", 36, 22, 64'd5, 32'd1, 1'b0, 64'd2, 32'd3);
        send_pkt(1000);
        chk("t4_err", 64'(err_count), 64'd2);
        add_msg("E", 31, 33, 64'd11, 32'd77, 1'b0, 64'd0, 32'd0);
        send_pkt(1000);
        drain();
        chk_counts("t4");

        // Backpressure across two Adds
        saw_stall = 1'b0;
        hold = 30;
        add_msg("A", 36, 38, {$urandom, $urandom}, $urandom, 1'b0,
                {$urandom, $urandom}, $urandom);
        add_msg("F", 40, 42, {$urandom, $urandom}, $urandom, 1'b1,
                {$urandom, $urandom}, $urandom);
        send_pkt(1000);
        drain();
        chk("t5_stall", 64'(saw_stall), 64'd1);
        chk("t5_evt", 64'(evt_count), 64'(evt_exp));

        // Unknown type skipped, then Add
        add_msg("S", 12, 14, 64'd0, 32'd0, 1'b0, 64'd0, 32'd0);
        add_msg("A", 36, 38, 64'd42, 32'd9, 1'b0, 64'd3, 32'd4);
        send_pkt(1000);
        drain();
        chk_counts("t6");
        chk("t6_evt", 64'(evt_count), 64'(evt_exp));

        // Reset in the middle of an Add
        add_msg("A", 36, 38, 64'd1, 32'd2, 1'b1, 64'd3, 32'd4);
        send_pkt(3);
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        assert (got === '0) else begin
            failures++;
            $error("FAIL rst2_fields got=%h exp=0", got);
        end
        chk("rst2_valid", 64'(m_evt_valid), 64'd0);
        chk("rst2_msg", 64'(msg_count), 64'd0);
        chk("rst2_evt", 64'(evt_count), 64'd0);
        chk("rst2_err", 64'(err_count), 64'd0);
        exp_q.delete();
        msg_exp = 0;
        evt_exp = 0;
        err_exp = 0;
        rst_n = 1'b1;
        tick();
        add_msg("X", 23, 25, 64'd99, 32'd5, 1'b0, 64'd0, 32'd0);
        send_pkt(1000);
        drain();
        chk_counts("rst2_after");
        chk("rst2_after_evt", 64'(evt_count), 64'd1);

        // Random packets with random downstream readiness
        for (int pk = 0; pk < 60; pk++) begin
            nm = $urandom_range(1, 4);
            for (int m = 0; m < nm; m++) begin
                r   = $urandom_range(0, 99);
                tc  = tcs[$urandom_range(0, 6)];
                req = req_len(tc);
                len = (req != 0) ? req : $urandom_range(1, 48);
                if (r < 10 && req != 0) begin
                    len = $urandom_range(1, 48);
                    if (len == req) len = req - 1;
                end
                if (m == nm - 1 && r >= 88 && r < 94) begin
                    add_bad(($urandom_range(0, 1) == 0) ? 16'h0000
                            : 16'($urandom_range(49, 1000)), $urandom_range(0, 10));
                end else if (m == nm - 1 && r >= 94) begin
                    add_msg(tc, len, $urandom_range(1, len + 1), {$urandom, $urandom},
                            $urandom, 1'($urandom), {$urandom, $urandom}, $urandom);
                end else begin
                    add_msg(tc, len, len + 2, {$urandom, $urandom}, $urandom,
                            1'($urandom), {$urandom, $urandom}, $urandom);
                end
            end
            rmode = 1'b1;
            send_pkt(1000);
            chk_counts("rnd");
        end
        drain();
        chk("final_evt", 64'(evt_count), 64'(evt_exp));
        chk_counts("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
